// File: rtl/sudoku_pkg.sv
// Shared Sudoku constants, cell/index/unit types and small arithmetic helpers
// used by the check sequencer and the unit address mapper.
package sudoku_pkg;

    localparam int GRID_N          = 9;
    localparam int BOX_N           = 3;
    localparam int UNIT_CNT        = 27;
    localparam int CELLS_PER_CHECK = 243;

    typedef logic [3:0] cell_t;
    typedef logic [3:0] idx_t;
    typedef logic [4:0] unit_t;

    typedef enum logic [1:0] {
        UNIT_ROW,
        UNIT_COL,
        UNIT_BOX
    } unit_kind_e;

    function automatic unit_kind_e unit_kind(input unit_t u);
        if (u < 5'd9) begin
            return UNIT_ROW;
        end else if (u < 5'd18) begin
            return UNIT_COL;
        end
        return UNIT_BOX;
    endfunction

    // Indices here never exceed 8, so a comparison ladder replaces a divider.
    function automatic logic [1:0] div3(input idx_t x);
        if (x < 4'd3) begin
            return 2'd0;
        end else if (x < 4'd6) begin
            return 2'd1;
        end
        return 2'd2;
    endfunction

    function automatic logic [1:0] mod3(input idx_t x);
        case (x)
            4'd0, 4'd3, 4'd6: return 2'd0;
            4'd1, 4'd4, 4'd7: return 2'd1;
            default:          return 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/sudoku_unit_addr.sv
// Maps (unit, cell index) to the grid (row, col) visited for that unit.
// Purely combinational so the solver hint logic can share it.
module sudoku_unit_addr
    import sudoku_pkg::*;
(
    input  logic [4:0] unit_i,
    input  logic [3:0] k_i,
    output logic [3:0] row_o,
    output logic [3:0] col_o
);

    idx_t       box_idx;
    logic [1:0] box_q3;
    logic [1:0] box_r3;
    logic [1:0] k_q3;
    logic [1:0] k_r3;

    // Low-nibble subtraction is exact because the results stay within 0..8.
    assign box_idx = unit_i[3:0] - 4'd2;
    assign box_q3  = div3(box_idx);
    assign box_r3  = mod3(box_idx);
    assign k_q3    = div3(k_i);
    assign k_r3    = mod3(k_i);

    always_comb begin
        row_o = '0;
        col_o = '0;
        case (unit_kind(unit_i))
            UNIT_ROW: begin
                row_o = unit_i[3:0];
                col_o = k_i;
            end
            UNIT_COL: begin
                row_o = k_i;
                col_o = unit_i[3:0] - 4'd9;
            end
            default: begin
                row_o = {2'b00, box_q3} + {1'b0, box_q3, 1'b0} + {2'b00, k_q3};
                col_o = {2'b00, box_r3} + {1'b0, box_r3, 1'b0} + {2'b00, k_r3};
            end
        endcase
    end

endmodule

// File: rtl/sudoku_check_sequencer.sv
// Walks all 27 Sudoku units one cell read per cycle, checks each returned value
// against a per-unit digit mask and latches the first illegal cell found.
module sudoku_check_sequencer
    import sudoku_pkg::*;
#(
    parameter bit ALLOW_EMPTY = 1'b1,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic       rd_en,
    output logic [3:0] rd_row,
    output logic [3:0] rd_col,
    input  logic [3:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [4:0] err_unit,
    output logic [3:0] err_row,
    output logic [3:0] err_col
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

    state_e     state_q;
    unit_t      u_q, u_d, chk_u_q, err_unit_q;
    idx_t       k_q, k_d, chk_k_q;
    idx_t       rd_row_q, rd_col_q, chk_row_q, chk_col_q, err_row_q, err_col_q;
    idx_t       map_row, map_col;
    logic       rd_en_q, chk_vld_q, busy_q, done_q, err_q;
    logic [8:0] mask_q, mask_base, mask_d, digit_hot;
    logic       last_rd, bad, stop;

    // Counters always describe the read currently on the bus; u_d/k_d is the next one.
    always_comb begin
        u_d = u_q;
        k_d = k_q;
        if (state_q == S_IDLE || state_q == S_DONE) begin
            u_d = '0;
            k_d = '0;
        end else if (k_q == 4'd8) begin
            k_d = '0;
            u_d = u_q + 5'd1;
        end else begin
            k_d = k_q + 4'd1;
        end
    end

    sudoku_unit_addr u_addr (
        .unit_i (u_d),
        .k_i    (k_d),
        .row_o  (map_row),
        .col_o  (map_col)
    );

    generate
        for (genvar gi = 0; gi < GRID_N; gi++) begin : g_digit
            assign digit_hot[gi] = (rd_data == 4'(gi + 1));
        end
    endgenerate

    assign last_rd   = (u_q == 5'(UNIT_CNT - 1)) && (k_q == 4'(GRID_N - 1));
    assign mask_base = (chk_k_q == '0) ? '0 : mask_q;
    assign mask_d    = mask_base | digit_hot;
    assign bad       = chk_vld_q && ((rd_data > 4'd9) ||
                                     ((rd_data == '0) && !ALLOW_EMPTY) ||
                                     (|(mask_base & digit_hot)));
    assign stop      = STOP_ON_ERR && bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            u_q        <= '0;
            k_q        <= '0;
            rd_en_q    <= 1'b0;
            rd_row_q   <= '0;
            rd_col_q   <= '0;
            chk_vld_q  <= 1'b0;
            chk_u_q    <= '0;
            chk_k_q    <= '0;
            chk_row_q  <= '0;
            chk_col_q  <= '0;
            mask_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_unit_q <= '0;
            err_row_q  <= '0;
            err_col_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q    <= S_RUN;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        err_q      <= 1'b0;
                        err_unit_q <= '0;
                        err_row_q  <= '0;
                        err_col_q  <= '0;
                        mask_q     <= '0;
                        chk_vld_q  <= 1'b0;
                        rd_en_q    <= 1'b1;
                        rd_row_q   <= map_row;
                        rd_col_q   <= map_col;
                        u_q        <= u_d;
                        k_q        <= k_d;
                    end
                end
                S_RUN, S_DRAIN: begin
                    if (abort) begin
                        state_q    <= S_IDLE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b0;
                        rd_en_q    <= 1'b0;
                        chk_vld_q  <= 1'b0;
                        mask_q     <= '0;
                        u_q        <= '0;
                        k_q        <= '0;
                        err_q      <= 1'b0;
                        err_unit_q <= '0;
                        err_row_q  <= '0;
                        err_col_q  <= '0;
                    end else begin
                        if (chk_vld_q) begin
                            mask_q <= mask_d;
                        end
                        if (bad && !err_q) begin
                            err_q      <= 1'b1;
                            err_unit_q <= chk_u_q;
                            err_row_q  <= chk_row_q;
                            err_col_q  <= chk_col_q;
                        end
                        chk_u_q   <= u_q;
                        chk_k_q   <= k_q;
                        chk_row_q <= rd_row_q;
                        chk_col_q <= rd_col_q;
                        if (state_q == S_RUN) begin
                            // On an early stop the read already in flight is dropped.
                            chk_vld_q <= !stop;
                            if (stop || last_rd) begin
                                state_q <= S_DRAIN;
                                rd_en_q <= 1'b0;
                            end else begin
                                rd_en_q  <= 1'b1;
                                rd_row_q <= map_row;
                                rd_col_q <= map_col;
                                u_q      <= u_d;
                                k_q      <= k_d;
                            end
                        end else begin
                            state_q   <= S_DONE;
                            chk_vld_q <= 1'b0;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rd_en    = rd_en_q;
    assign rd_row   = rd_row_q;
    assign rd_col   = rd_col_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign err_unit = err_unit_q;
    assign err_row  = err_row_q;
    assign err_col  = err_col_q;

endmodule

// File: tb/tb_sudoku_check_sequencer.sv
// Directed bench: two sequencer instances (default parameters, and strict/stop-on-error)
// read a shared bench-owned grid; results are compared with hand-computed values.
module tb_sudoku_check_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_a = 1'b0, start_b = 1'b0;
    logic       abort_a = 1'b0, abort_b = 1'b0;
    logic       rd_en_a, rd_en_b;
    logic [3:0] rd_row_a, rd_col_a, rd_row_b, rd_col_b;
    logic [3:0] rd_data_a = '0, rd_data_b = '0;
    logic       busy_a, done_a, err_a, busy_b, done_b, err_b;
    logic [4:0] err_unit_a, err_unit_b;
    logic [3:0] err_row_a, err_col_a, err_row_b, err_col_b;

    logic [3:0] g [9][9];
    logic       sel_b = 1'b0;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    sudoku_check_sequencer #(.ALLOW_EMPTY(1'b1), .STOP_ON_ERR(1'b0)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
        .rd_en(rd_en_a), .rd_row(rd_row_a), .rd_col(rd_col_a), .rd_data(rd_data_a),
        .busy(busy_a), .done(done_a), .err(err_a), .err_unit(err_unit_a),
        .err_row(err_row_a), .err_col(err_col_a)
    );

    sudoku_check_sequencer #(.ALLOW_EMPTY(1'b0), .STOP_ON_ERR(1'b1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
        .rd_en(rd_en_b), .rd_row(rd_row_b), .rd_col(rd_col_b), .rd_data(rd_data_b),
        .busy(busy_b), .done(done_b), .err(err_b), .err_unit(err_unit_b),
        .err_row(err_row_b), .err_col(err_col_b)
    );

    // Grid storage model: data is returned one cycle after the strobe.
    always @(posedge clk) begin
        if (rd_en_a && rd_row_a < 9 && rd_col_a < 9) rd_data_a <= g[rd_row_a][rd_col_a];
        else rd_data_a <= 4'd0;
        if (rd_en_b && rd_row_b < 9 && rd_col_b < 9) rd_data_b <= g[rd_row_b][rd_col_b];
        else rd_data_b <= 4'd0;
    end

    wire       s_rd_en = sel_b ? rd_en_b : rd_en_a;
    wire [3:0] s_row   = sel_b ? rd_row_b : rd_row_a;
    wire [3:0] s_col   = sel_b ? rd_col_b : rd_col_a;
    wire       s_busy  = sel_b ? busy_b : busy_a;
    wire       s_done  = sel_b ? done_b : done_a;
    wire       s_err   = sel_b ? err_b : err_a;
    wire [4:0] s_unit  = sel_b ? err_unit_b : err_unit_a;
    wire [3:0] s_erow  = sel_b ? err_row_b : err_row_a;
    wire [3:0] s_ecol  = sel_b ? err_col_b : err_col_a;

    task automatic check_eq(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic fill_base();
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
                g[r][c] = 4'(((3 * r + r / 3 + c) % 9) + 1);
    endtask

    function automatic void exp_addr(input int idx, output int r, output int c);
        int u, k, b;
        u = idx / 9;
        k = idx % 9;
        if (u < 9) begin
            r = u; c = k;
        end else if (u < 18) begin
            r = k; c = u - 9;
        end else begin
            b = u - 18;
            r = 3 * (b / 3) + k / 3;
            c = 3 * (b % 3) + k % 3;
        end
    endfunction

    // One start pulse, then observe up to 400 cycles; cycle 0 is the start-sampling cycle.
    task automatic do_run(input string name, output int n_rd, output int first_rd,
                          output int last_rd, output int done_cyc, output int err_at1,
                          output int busy_at1, output int busy_at_done, output int addr_bad);
        int er, ec;
        @(negedge clk);
        if (sel_b) start_b = 1'b1; else start_a = 1'b1;
        n_rd = 0; first_rd = -1; last_rd = -1; done_cyc = -1;
        err_at1 = -1; busy_at1 = -1; busy_at_done = -1; addr_bad = 0;
        for (int cyc = 1; cyc <= 400 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            start_a = 1'b0;
            start_b = 1'b0;
            if (cyc == 1) begin
                err_at1  = int'(s_err);
                busy_at1 = int'(s_busy);
            end
            if (s_rd_en) begin
                exp_addr(n_rd, er, ec);
                if (int'(s_row) != er || int'(s_col) != ec) addr_bad++;
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
                n_rd++;
            end
            if (s_done) begin
                done_cyc     = cyc;
                busy_at_done = int'(s_busy);
            end
        end
        $display("run %s: reads=%0d first=%0d last=%0d done@%0d err=%0d unit=%0d row=%0d col=%0d",
                 name, n_rd, first_rd, last_rd, done_cyc, s_err, s_unit, s_erow, s_ecol);
    endtask

    initial begin
        int n_rd, first_rd, last_rd, done_cyc, err_at1, busy_at1, busy_at_done, addr_bad;
        int cyc;

        fill_base();
        repeat (3) @(negedge clk);
        check_eq("reset_a_outputs", int'({rd_en_a, rd_row_a, rd_col_a, busy_a, done_a, err_a,
                                          err_unit_a, err_row_a, err_col_a}), 0);
        check_eq("reset_b_outputs", int'({rd_en_b, rd_row_b, rd_col_b, busy_b, done_b, err_b,
                                          err_unit_b, err_row_b, err_col_b}), 0);
        rst = 1'b0;

        // 1: solved grid
        sel_b = 1'b0;
        do_run("valid", n_rd, first_rd, last_rd, done_cyc, err_at1, busy_at1, busy_at_done, addr_bad);
        check_eq("valid_busy_c1", busy_at1, 1);
        check_eq("valid_first_rd", first_rd, 1);
        check_eq("valid_last_rd", last_rd, 243);
        check_eq("valid_n_rd", n_rd, 243);
        check_eq("valid_addr_seq", addr_bad, 0);
        check_eq("valid_done_cyc", done_cyc, 245);
        check_eq("valid_busy_done", busy_at_done, 0);
        check_eq("valid_err", int'(err_a), 0);

        // 2: row duplicate of 5 at (0,0)/(0,4)
        fill_base();
        g[0][0] = 4'd5;
        do_run("row_dup", n_rd, first_rd, last_rd, done_cyc, err_at1, busy_at1, busy_at_done, addr_bad);
        check_eq("rowdup_err", int'(err_a), 1);
        check_eq("rowdup_unit", int'(err_unit_a), 0);
        check_eq("rowdup_row", int'(err_row_a), 0);
        check_eq("rowdup_col", int'(err_col_a), 4);
        check_eq("rowdup_done_cyc", done_cyc, 245);

        // 3: column-only clash of 7 at (2,3)/(6,3): swap rows 6,7, swap (6,3)/(6,4), relabel 1->7
        fill_base();
        for (int c = 0; c < 9; c++) begin
            logic [3:0] t;
            t = g[6][c]; g[6][c] = g[7][c]; g[7][c] = t;
        end
        begin
            logic [3:0] t;
            t = g[6][3]; g[6][3] = g[6][4]; g[6][4] = t;
        end
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++)
                g[r][c] = 4'(((int'(g[r][c]) + 5) % 9) + 1);
        do_run("col_dup", n_rd, first_rd, last_rd, done_cyc, err_at1, busy_at1, busy_at_done, addr_bad);
        check_eq("coldup_cleared_on_restart", err_at1, 0);
        check_eq("coldup_7_at_2_3", int'(g[2][3]), 7);
        check_eq("coldup_unit", int'(err_unit_a), 12);
        check_eq("coldup_row", int'(err_row_a), 6);
        check_eq("coldup_col", int'(err_col_a), 3);

        // 4: empty cell at (8,8)
        fill_base();
        g[8][8] = 4'd0;
        do_run("empty_allowed", n_rd, first_rd, last_rd, done_cyc, err_at1, busy_at1, busy_at_done, addr_bad);
        check_eq("empty_allowed_err", int'(err_a), 0);
        check_eq("empty_allowed_done", done_cyc, 245);
        sel_b = 1'b1;
        do_run("empty_strict", n_rd, first_rd, last_rd, done_cyc, err_at1, busy_at1, busy_at_done, addr_bad);
        check_eq("empty_strict_err", int'(err_b), 1);
        check_eq("empty_strict_unit", int'(err_unit_b), 8);
        check_eq("empty_strict_row", int'(err_row_b), 8);
        check_eq("empty_strict_col", int'(err_col_b), 8);

        // 5: illegal 12 at (4,4), stop on error: read #40 at cycle 41, detected at 42
        fill_base();
        g[4][4] = 4'd12;
        do_run("stop_on_err", n_rd, first_rd, last_rd, done_cyc, err_at1, busy_at1, busy_at_done, addr_bad);
        check_eq("stop_cleared_on_restart", err_at1, 0);
        check_eq("stop_n_rd", n_rd, 42);
        check_eq("stop_last_rd", last_rd, 42);
        check_eq("stop_done_cyc", done_cyc, 44);
        check_eq("stop_unit", int'(err_unit_b), 4);
        check_eq("stop_row", int'(err_row_b), 4);
        check_eq("stop_col", int'(err_col_b), 4);

        // 6: abort at cycle 100, then a fresh full run
        fill_base();
        sel_b = 1'b0;
        @(negedge clk);
        start_a = 1'b1;
        cyc = 0;
        while (cyc < 100) begin
            @(negedge clk);
            start_a = 1'b0;
            cyc++;
        end
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        $display("abort: busy=%0d done=%0d rd_en=%0d err=%0d", busy_a, done_a, rd_en_a, err_a);
        check_eq("abort_busy", int'(busy_a), 0);
        check_eq("abort_done", int'(done_a), 0);
        check_eq("abort_rd_en", int'(rd_en_a), 0);
        check_eq("abort_err", int'(err_a), 0);
        do_run("after_abort", n_rd, first_rd, last_rd, done_cyc, err_at1, busy_at1, busy_at_done, addr_bad);
        check_eq("after_abort_n_rd", n_rd, 243);
        check_eq("after_abort_done", done_cyc, 245);
        check_eq("after_abort_err", int'(err_a), 0);

        // reset in the middle of a run
        @(negedge clk);
        start_a = 1'b1;
        repeat (50) begin
            @(negedge clk);
            start_a = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        $display("midrun_rst: rd_en=%0d busy=%0d done=%0d", rd_en_a, busy_a, done_a);
        check_eq("midrun_rst_outputs", int'({rd_en_a, rd_row_a, rd_col_a, busy_a, done_a, err_a,
                                             err_unit_a, err_row_a, err_col_a}), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
